hybrid_noc_router_be_wrr_arbiter: RTL and testbench

Weighted round-robin, packet-locking arbiter for best-effort traffic, one instance per router output port. It is the next generation of the plain round-robin BE arbiter: each input port gets a run-time programmable weight, which is the number of consecutive packets it may send per turn. Weight 0 masks the port. Sits between the input-port BE FIFOs and the output-port BE buffer; drives the output mux select.

---
 rtl/hybrid_noc_router_be_wrr_arbiter.sv | 119 +++++++++++
 tb/tb_hybrid_noc_router_be_wrr_arbiter.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hybrid_noc_router_be_wrr_arbiter.sv
// Weighted round-robin, packet-locking best-effort arbiter for one router output port.
// Optional per-port forwarded-packet counters are built when HYBRID_NOC_BE_ARB_STATS_EN is defined.
module hybrid_noc_router_be_wrr_arbiter #(
  parameter int PORTS    = 5,
  parameter int WEIGHT_W = 4,
  parameter int STAT_W   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [PORTS-1:0]            in_valid,
  input  logic [PORTS-1:0]            in_last,
  output logic [PORTS-1:0]            in_ready,
  input  logic [PORTS*WEIGHT_W-1:0]   weight,
  input  logic                        buffer_ready,
  output logic                        buffer_valid,
  output logic                        buffer_last,
  output logic [$clog2(PORTS)-1:0]    select,
  output logic [PORTS*STAT_W-1:0]     pkt_count
);

  localparam int SEL_W = $clog2(PORTS);

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t              state, state_nxt;
  logic [SEL_W-1:0]    ptr, ptr_nxt;
  logic [WEIGHT_W-1:0] credit, credit_nxt;

  logic [PORTS-1:0]    elig;
  logic                keep_turn;
  logic                scan_vld;
  logic [SEL_W-1:0]    scan_idx;

  always_comb begin
    for (int i = 0; i < PORTS; i++) begin
      elig[i] = in_valid[i] & (|weight[i*WEIGHT_W +: WEIGHT_W]);
    end
  end

  // The current owner keeps the turn while it still has packet credit.
  assign keep_turn = elig[ptr] & (|credit);

  // Scan ptr+1 .. ptr+PORTS; iterating downwards lets the nearest eligible port win.
  always_comb begin
    scan_vld = 1'b0;
    scan_idx = ptr;
    for (int k = PORTS; k >= 1; k--) begin
      if (elig[(int'(ptr) + k) % PORTS]) begin
        scan_vld = 1'b1;
        scan_idx = SEL_W'((int'(ptr) + k) % PORTS);
      end
    end
  end

  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    credit_nxt   = credit;
    select       = ptr;
    buffer_valid = 1'b0;
    in_ready     = '0;
    if (state == LOCKED) begin
      buffer_valid = in_valid[ptr];
      if (in_valid[ptr] && buffer_ready) begin
        in_ready[ptr] = 1'b1;
        if (in_last[ptr]) state_nxt = IDLE;
      end
    end else if (keep_turn || scan_vld) begin
      select = keep_turn ? ptr : scan_idx;
      if (buffer_ready) begin
        buffer_valid     = 1'b1;
        in_ready[select] = 1'b1;
        ptr_nxt          = select;
        credit_nxt       = keep_turn ? credit - 1'b1
                                     : weight[select*WEIGHT_W +: WEIGHT_W] - 1'b1;
        if (!in_last[select]) state_nxt = LOCKED;
      end
    end
  end

  assign buffer_last = in_last[select];

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= '0;
      credit <= '0;
    end else begin
      state  <= state_nxt;
      ptr    <= ptr_nxt;
      credit <= credit_nxt;
    end
  end

`ifdef HYBRID_NOC_BE_ARB_STATS_EN
  logic [STAT_W-1:0] cnt [PORTS];

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PORTS; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < PORTS; i++) begin
        if (in_ready[i] && in_last[i]) cnt[i] <= sat_inc(cnt[i]);
      end
    end
  end

  for (genvar g = 0; g < PORTS; g++) begin : g_cnt
    assign pkt_count[g*STAT_W +: STAT_W] = cnt[g];
  end
`else
  assign pkt_count = '0;
`endif

endmodule

// File: tb/tb_hybrid_noc_router_be_wrr_arbiter.sv
// Directed bench for the weighted round-robin BE arbiter with a turn-based reference model.
// Build with HYBRID_NOC_BE_ARB_STATS_EN defined to also exercise the packet counters.
module tb_hybrid_noc_router_be_wrr_arbiter;

  localparam int P  = 5;
  localparam int WW = 4;
  localparam int SW = 16;
  localparam int SAT = (1 << SW) - 1;
`ifdef HYBRID_NOC_BE_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              clk;
  logic              rst;
  logic [P-1:0]      in_valid;
  logic [P-1:0]      in_last;
  logic [P-1:0]      in_ready;
  logic [P*WW-1:0]   weight;
  logic              buffer_ready;
  logic              buffer_valid;
  logic              buffer_last;
  logic [2:0]        select;
  logic [P*SW-1:0]   pkt_count;

  hybrid_noc_router_be_wrr_arbiter #(.PORTS(P), .WEIGHT_W(WW), .STAT_W(SW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
    .weight(weight), .buffer_ready(buffer_ready), .buffer_valid(buffer_valid),
    .buffer_last(buffer_last), .select(select), .pkt_count(pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- source driver ----------------
  int pkts [P];
  int flen [P];
  int fpos [P];
  bit hold [P];
  int wgt  [P];
  logic [P-1:0] rdy_s = '0;

  function automatic void drive();
    for (int i = 0; i < P; i++) begin
      in_valid[i] = (pkts[i] > 0) && !hold[i];
      in_last[i]  = (fpos[i] == flen[i] - 1);
      weight[i*WW +: WW] = WW'(wgt[i]);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < P; i++) begin
      if (rdy_s[i]) begin
        if (fpos[i] == flen[i] - 1) begin
          fpos[i] = 0;
          pkts[i]--;
        end else begin
          fpos[i]++;
        end
      end
    end
    drive();
  endtask

  // ---------------- reference model ----------------
  // A turn belongs to one port; turn_left is how many more packet heads it may start.
  bit m_in_pkt = 1'b0;
  int m_turn   = 0;
  int m_left   = 0;
  int m_cnt [P];

  int   e_sel, e_grant, e_wt;
  bit   e_bv, e_xfer, e_new, e_last;
  logic [P-1:0] e_rdy;
  bit   chk_en = 1'b0;

  bit   d_mid = 1'b0;
  int   xfer_log[$];
  int   head_log[$];

  function automatic bit eligible(int i);
    return in_valid[i] && (weight[i*WW +: WW] != 0);
  endfunction

  function automatic void model_eval();
    bit found;
    found   = 1'b0;
    e_new   = 1'b0;
    e_grant = m_turn;
    if (m_in_pkt) begin
      e_sel  = m_turn;
      e_bv   = in_valid[m_turn];
      e_xfer = e_bv && buffer_ready;
    end else begin
      if (eligible(m_turn) && m_left > 0) found = 1'b1;
      else begin
        for (int k = 1; k <= P; k++) begin
          if (!found && eligible((m_turn + k) % P)) begin
            found   = 1'b1;
            e_grant = (m_turn + k) % P;
            e_new   = 1'b1;
          end
        end
      end
      e_sel  = found ? e_grant : m_turn;
      e_bv   = found && buffer_ready;
      e_xfer = e_bv;
    end
    e_rdy  = e_xfer ? P'(1) << e_sel : '0;
    e_last = in_last[e_sel];
    e_wt   = int'(weight[e_sel*WW +: WW]);
  endfunction

  always @(negedge clk) begin
    model_eval();
    if (chk_en) begin
      chk("select", 32'(select), 32'(e_sel));
      chk("buffer_valid", 32'(buffer_valid), 32'(e_bv));
      chk("in_ready", 32'(in_ready), 32'(e_rdy));
      chk("buffer_last", 32'(buffer_last), 32'(e_last));
      for (int i = 0; i < P; i++)
        chk($sformatf("pkt_count[%0d]", i), 32'(pkt_count[i*SW +: SW]), STATS ? 32'(m_cnt[i]) : 32'd0);
      if (buffer_valid && buffer_ready) begin
        xfer_log.push_back(int'(select));
        if (!d_mid) head_log.push_back(int'(select));
        d_mid = !buffer_last;
      end
    end
    if (rst) d_mid = 1'b0;
    rdy_s = in_ready;
  end

  always @(posedge clk) begin
    if (rst) begin
      m_in_pkt <= 1'b0;
      m_turn   <= 0;
      m_left   <= 0;
      for (int i = 0; i < P; i++) m_cnt[i] <= 0;
    end else if (e_xfer) begin
      if (!m_in_pkt) begin
        if (e_new) begin
          m_turn <= e_grant;
          m_left <= e_wt - 1;
        end else begin
          m_left <= m_left - 1;
        end
      end
      m_in_pkt <= !e_last;
      if (e_last && m_cnt[e_sel] < SAT) m_cnt[e_sel] <= m_cnt[e_sel] + 1;
    end
  end

  task automatic chk_queue(input string nm, input int q[$], input int exp[]);
    chk({nm, "_len"}, 32'(q.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < q.size(); i++)
      chk($sformatf("%s_%0d", nm, i), 32'(q[i]), 32'(exp[i]));
  endtask

  task automatic clear_src();
    for (int i = 0; i < P; i++) begin
      pkts[i] = 0; fpos[i] = 0; flen[i] = 1; hold[i] = 1'b0;
    end
    drive();
  endtask

  initial begin
    rst = 1'b1;
    buffer_ready = 1'b1;
    for (int i = 0; i < P; i++) wgt[i] = 1;
    clear_src();
    repeat (2) tick();
    rst = 1'b0;
    chk_en = 1'b1;

    // reset state, no requests
    @(negedge clk);
    chk("rst_select", 32'(select), 32'd0);
    chk("rst_bvalid", 32'(buffer_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    tick();

    // all weights 1: move ptr to port 4, then 3-flit packets from every port
    pkts[4] = 1; drive();
    tick();
    xfer_log.delete(); head_log.delete();
    for (int i = 0; i < P; i++) begin flen[i] = 3; pkts[i] = 1; end
    pkts[0] = 2; drive();
    repeat (18) tick();
    chk("t1_xfers_no_bubble", 32'(xfer_log.size()), 32'd18);
    chk_queue("t1_order", head_log, '{0, 1, 2, 3, 4, 0});
    clear_src();

    // weights {3,1,0,0,0}: ptr moved to port 1 first
    pkts[1] = 1; drive();
    tick();
    xfer_log.delete(); head_log.delete();
    wgt = '{3, 1, 0, 0, 0};
    pkts[0] = 100; pkts[1] = 100; pkts[2] = 100; drive();
    repeat (8) tick();
    chk_queue("t2_order", head_log, '{0, 0, 0, 1, 0, 0, 0, 1});
    clear_src();

    // mid-packet stall on port 0 with port 1 waiting
    wgt = '{1, 1, 1, 1, 1};
    xfer_log.delete(); head_log.delete();
    pkts[0] = 1; flen[0] = 4; pkts[1] = 1; drive();
    repeat (2) tick();
    hold[0] = 1'b1; drive();
    @(negedge clk);
    chk("t3_stall1_bvalid", 32'(buffer_valid), 32'd0);
    chk("t3_stall1_ready", 32'(in_ready), 32'd0);
    tick();
    @(negedge clk);
    chk("t3_stall2_bvalid", 32'(buffer_valid), 32'd0);
    chk("t3_stall2_ready", 32'(in_ready), 32'd0);
    tick();
    hold[0] = 1'b0; drive();
    repeat (3) tick();
    chk_queue("t3_xfers", xfer_log, '{0, 0, 0, 0, 1});
    clear_src();

    // output buffer back-pressure right after reset, ports 1 and 3 waiting
    rst = 1'b1;
    tick();
    rst = 1'b0;
    buffer_ready = 1'b0;
    xfer_log.delete(); head_log.delete();
    pkts[1] = 1; pkts[3] = 1; drive();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("t4_stall%0d_ready", c), 32'(in_ready), 32'd0);
      chk($sformatf("t4_stall%0d_bvalid", c), 32'(buffer_valid), 32'd0);
      tick();
    end
    buffer_ready = 1'b1; drive();
    repeat (2) tick();
    chk_queue("t4_order", head_log, '{1, 3});
    clear_src();

    // reset while locked on port 2
    xfer_log.delete(); head_log.delete();
    pkts[2] = 1; flen[2] = 3; drive();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    pkts[2] = 0; fpos[2] = 0; drive();
    @(negedge clk);
    chk("t5_select", 32'(select), 32'd0);
    chk("t5_bvalid", 32'(buffer_valid), 32'd0);
    tick();
    pkts[2] = 1; flen[2] = 1; drive();
    @(negedge clk);
    chk("t5_regrant_bvalid", 32'(buffer_valid), 32'd1);
    chk("t5_regrant_select", 32'(select), 32'd2);
    chk("t5_regrant_ready", 32'(in_ready), 32'd4);
    tick();
    chk("t5_count2", 32'(pkt_count[2*SW +: SW]), STATS ? 32'd1 : 32'd0);
    clear_src();

    // counter saturation on port 1
    pkts[1] = 70000; drive();
    repeat (65534) tick();
    chk("t6_count_pre_sat", 32'(pkt_count[1*SW +: SW]), STATS ? 32'd65534 : 32'd0);
    repeat (70000 - 65534) tick();
    chk("t6_count_sat", 32'(pkt_count[1*SW +: SW]), STATS ? 32'd65535 : 32'd0);
    clear_src();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
